spart_driver: RTL and testbench

- Processor-side bus master for the SPART peripheral. It drives iocs/iorw/ioaddr/databus the way the CPU would.
- After reset or a baud-select change, it programs the SPART baud divisor. It then polls rda and reads each received byte.
- Each received byte is held in a one-deep buffer and written back to the SPART transmitter when tbr is high (echo).
- Serves as the board-level test master and as the reference initiator for SPART verification.

---
 rtl/spart_driver_if.sv | 12 +
 rtl/spart_driver.sv | 144 ++++++++++++++
 tb/tb_spart_driver.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spart_driver_if.sv
// Processor-side SPART control/handshake signals: chip select, direction, address, rda/tbr status.
// Combinational wiring only; the master drives iocs/iorw/ioaddr and the SPART drives rda/tbr.
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor, reads received bytes and echoes them back to the transmitter.
// Bus outputs are registered; rda in IDLE gives an RD bus cycle 2 clocks later; echo waits for tbr (no drop).
module spart_driver #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    br_cfg,
    spart_driver_if.master bus,
    inout  wire  [7:0]    databus,
    output logic [7:0]    rx_byte,
    output logic          rx_strobe,
    output logic [15:0]   tx_count,
    output logic          overrun
);

    localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / (16 * 4800)  - 1);
    localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / (16 * 9600)  - 1);
    localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / (16 * 19200) - 1);
    localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ / (16 * 38400) - 1);

    typedef enum logic [2:0] {HI, LO, IDLE, RD, RD_WAIT, WR, WR_WAIT} state_t;

    state_t      state;
    logic [1:0]  cfg_meta;
    logic [1:0]  cfg_sync;
    logic [1:0]  cfg_q;
    logic        pending;
    logic [1:0]  wait_cnt;
    logic        drive_en;
    logic [7:0]  drive_dat;
    logic [15:0] div_new;
    logic [15:0] div_cur;
    logic        rd_cycle;

    function automatic logic [15:0] div_of(input logic [1:0] sel);
        case (sel)
            2'b00:   div_of = DIV_4800;
            2'b01:   div_of = DIV_9600;
            2'b10:   div_of = DIV_19200;
            default: div_of = DIV_38400;
        endcase
    endfunction

    assign div_new  = div_of(cfg_sync);
    assign div_cur  = div_of(cfg_q);
    assign databus  = drive_en ? drive_dat : 8'hzz;
    assign rd_cycle = !bus.iocs && bus.iorw && (bus.ioaddr == 2'b00);

    always_ff @(posedge clk) begin
        cfg_meta <= br_cfg;
        cfg_sync <= cfg_meta;
    end

    // The FSM state names the bus cycle issued on the next edge, so outputs stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HI;
            bus.iocs   <= 1'b1;
            bus.iorw   <= 1'b1;
            bus.ioaddr <= 2'b01;
            drive_en   <= 1'b0;
            drive_dat  <= 8'h00;
            rx_byte    <= 8'h00;
            rx_strobe  <= 1'b0;
            tx_count   <= 16'h0000;
            overrun    <= 1'b0;
            pending    <= 1'b0;
            cfg_q      <= 2'b00;
            wait_cnt   <= 2'd0;
        end else begin
            bus.iocs   <= 1'b1;
            bus.iorw   <= 1'b1;
            bus.ioaddr <= 2'b01;
            drive_en   <= 1'b0;
            rx_strobe  <= 1'b0;

            if (rd_cycle) begin
                rx_byte   <= databus;
                rx_strobe <= 1'b1;
                overrun   <= overrun | pending;
                pending   <= 1'b1;
            end

            case (state)
                HI: begin
                    bus.iocs   <= 1'b0;
                    bus.iorw   <= 1'b0;
                    bus.ioaddr <= 2'b11;
                    drive_en   <= 1'b1;
                    drive_dat  <= div_new[15:8];
                    cfg_q      <= cfg_sync;
                    state      <= LO;
                end
                LO: begin
                    bus.iocs   <= 1'b0;
                    bus.iorw   <= 1'b0;
                    bus.ioaddr <= 2'b10;
                    drive_en   <= 1'b1;
                    drive_dat  <= div_cur[7:0];
                    state      <= IDLE;
                end
                IDLE: begin
                    if (cfg_sync != cfg_q)
                        state <= HI;
                    else if (bus.rda)
                        state <= RD;
                    else if (pending && bus.tbr)
                        state <= WR;
                end
                RD: begin
                    bus.iocs   <= 1'b0;
                    bus.iorw   <= 1'b1;
                    bus.ioaddr <= 2'b00;
                    state      <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Hold off until rda drops so one frame is read only once.
                    if (!bus.rda)
                        state <= IDLE;
                end
                WR: begin
                    bus.iocs   <= 1'b0;
                    bus.iorw   <= 1'b0;
                    bus.ioaddr <= 2'b00;
                    drive_en   <= 1'b1;
                    drive_dat  <= rx_byte;
                    pending    <= 1'b0;
                    tx_count   <= tx_count + 16'd1;
                    wait_cnt   <= 2'd0;
                    state      <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (!bus.tbr || wait_cnt == 2'd3)
                        state <= IDLE;
                    else
                        wait_cnt <= wait_cnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: divisor programming, echo, overrun, rda hold and reset during a write.
module tb_spart_driver;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  br_cfg;
    logic [7:0]  rx_val;
    wire  [7:0]  databus;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic [15:0] tx_count;
    logic        overrun;
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    spart_driver_if sif();

    // SPART-side model: drives the rx byte on a data read and 0xA5 on any other read-direction cycle.
    assign databus = sif.iorw ? ((!sif.iocs && sif.ioaddr == 2'b00) ? rx_val : 8'hA5) : 8'hzz;

    spart_driver #(.CLK_FREQ(50000000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .br_cfg    (br_cfg),
        .bus       (sif),
        .databus   (databus),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .tx_count  (tx_count),
        .overrun   (overrun)
    );

    function automatic bit rd_cyc();
        return !sif.iocs && sif.iorw && sif.ioaddr == 2'b00;
    endfunction

    function automatic bit wr_cyc();
        return !sif.iocs && !sif.iorw && sif.ioaddr == 2'b00;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; br_cfg = 2'b01; rx_val = 8'h00; sif.rda = 1'b0; sif.tbr = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (sif.iocs !== 1'b1) $display("FAIL rst_iocs got %b want 1", sif.iocs); else passed++;
        total++; if (sif.iorw !== 1'b1) $display("FAIL rst_iorw got %b want 1", sif.iorw); else passed++;
        total++; if (sif.ioaddr !== 2'b01) $display("FAIL rst_ioaddr got %b want 01", sif.ioaddr); else passed++;
        total++; if (databus !== 8'hA5) $display("FAIL rst_bus_released got %h want a5", databus); else passed++;
        total++; if (rx_byte !== 8'h00 || rx_strobe !== 1'b0) $display("FAIL rst_rx got %h/%b want 00/0", rx_byte, rx_strobe); else passed++;
        total++; if (tx_count !== 16'h0000 || overrun !== 1'b0) $display("FAIL rst_cnt got %h/%b want 0000/0", tx_count, overrun); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (sif.iocs !== 1'b0 || sif.iorw !== 1'b0 || sif.ioaddr !== 2'b11) $display("FAIL hi_ctrl got %b%b%b want 0011", sif.iocs, sif.iorw, sif.ioaddr); else passed++;
        total++; if (databus !== 8'h01) $display("FAIL hi_data got %h want 01", databus); else passed++;
        @(negedge clk);
        total++; if (sif.iocs !== 1'b0 || sif.iorw !== 1'b0 || sif.ioaddr !== 2'b10) $display("FAIL lo_ctrl got %b%b%b want 0010", sif.iocs, sif.iorw, sif.ioaddr); else passed++;
        total++; if (databus !== 8'h44) $display("FAIL lo_data got %h want 44", databus); else passed++;
        @(negedge clk);
        total++; if (sif.iocs !== 1'b1 || sif.iorw !== 1'b1 || sif.ioaddr !== 2'b01 || databus !== 8'hA5) $display("FAIL idle_after_prog got %b%b%b %h want 1101 a5", sif.iocs, sif.iorw, sif.ioaddr, databus); else passed++;
    endtask

    task automatic test_echo();
        int rd_at = -1, st_at = -1, wr_at = -1, rd_n = 0, st_n = 0, wr_n = 0;
        logic [7:0] wr_d = 8'h00;
        rx_val = 8'h5A; sif.tbr = 1'b1; sif.rda = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (rd_cyc()) begin rd_n++; rd_at = i; sif.rda = 1'b0; end
            if (rx_strobe) begin st_n++; st_at = i; end
            if (wr_cyc()) begin wr_n++; wr_at = i; wr_d = databus; sif.tbr = 1'b0; end
        end
        total++; if (rd_n !== 1 || rd_at !== 2) $display("FAIL echo_rd got n=%0d at=%0d want n=1 at=2", rd_n, rd_at); else passed++;
        total++; if (st_n !== 1 || st_at !== 3) $display("FAIL echo_strobe got n=%0d at=%0d want n=1 at=3", st_n, st_at); else passed++;
        total++; if (rx_byte !== 8'h5A) $display("FAIL echo_rx_byte got %h want 5a", rx_byte); else passed++;
        total++; if (wr_n !== 1 || wr_at !== 5) $display("FAIL echo_wr got n=%0d at=%0d want n=1 at=5", wr_n, wr_at); else passed++;
        total++; if (wr_d !== 8'h5A) $display("FAIL echo_wr_data got %h want 5a", wr_d); else passed++;
        total++; if (tx_count !== 16'd1 || overrun !== 1'b0) $display("FAIL echo_count got %0d/%b want 1/0", tx_count, overrun); else passed++;
    endtask

    task automatic test_br_change();
        int hi_at = -1, lo_at = -1;
        logic [7:0] hi_d = 8'hFF, lo_d = 8'hFF;
        br_cfg = 2'b11;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!sif.iocs && !sif.iorw && sif.ioaddr == 2'b11) begin hi_at = i; hi_d = databus; end
            if (!sif.iocs && !sif.iorw && sif.ioaddr == 2'b10) begin lo_at = i; lo_d = databus; end
        end
        total++; if (hi_at !== 4 || hi_d !== 8'h00) $display("FAIL br_hi got at=%0d %h want at=4 00", hi_at, hi_d); else passed++;
        total++; if (lo_at !== 5 || lo_d !== 8'h50) $display("FAIL br_lo got at=%0d %h want at=5 50", lo_at, lo_d); else passed++;
    endtask

    task automatic test_overrun();
        int wr_n = 0;
        logic [7:0] wr_d = 8'h00;
        logic [7:0] bytes [2];
        bit seen;
        bytes[0] = 8'h11; bytes[1] = 8'h22;
        sif.tbr = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rx_val = bytes[b]; sif.rda = 1'b1; seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                @(negedge clk);
                if (rd_cyc()) begin seen = 1'b1; sif.rda = 1'b0; end
            end
            total++; if (!seen) $display("FAIL ovr_rd_timeout byte %0d got no read want read", b); else passed++;
            sif.rda = 1'b0;
            repeat (3) @(negedge clk);
        end
        total++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", overrun); else passed++;
        total++; if (rx_byte !== 8'h22 || tx_count !== 16'd1) $display("FAIL ovr_hold got %h/%0d want 22/1", rx_byte, tx_count); else passed++;
        sif.tbr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wr_cyc()) begin wr_n++; wr_d = databus; sif.tbr = 1'b0; end
        end
        total++; if (wr_n !== 1 || wr_d !== 8'h22) $display("FAIL ovr_echo got n=%0d %h want n=1 22", wr_n, wr_d); else passed++;
        total++; if (tx_count !== 16'd2) $display("FAIL ovr_tx_count got %0d want 2", tx_count); else passed++;
    endtask

    task automatic test_rda_hold();
        int rd_n = 0, st_n = 0;
        sif.tbr = 1'b0; rx_val = 8'h3C; sif.rda = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) sif.rda = 1'b0;
            if (rd_cyc()) rd_n++;
            if (rx_strobe) st_n++;
        end
        total++; if (rd_n !== 1 || st_n !== 1) $display("FAIL hold_single_read got rd=%0d st=%0d want 1/1", rd_n, st_n); else passed++;
        total++; if (rx_byte !== 8'h3C) $display("FAIL hold_rx_byte got %h want 3c", rx_byte); else passed++;
    endtask

    task automatic test_reset_mid_wr();
        bit seen = 1'b0;
        sif.tbr = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (wr_cyc()) begin
                seen = 1'b1;
                total++; if (databus !== 8'h3C) $display("FAIL mid_wr_data got %h want 3c", databus); else passed++;
                rst_n = 1'b0;
                #1;
                total++; if (sif.iocs !== 1'b1 || sif.iorw !== 1'b1 || databus !== 8'hA5) $display("FAIL mid_wr_release got %b%b %h want 11 a5", sif.iocs, sif.iorw, databus); else passed++;
                total++; if (tx_count !== 16'd0 || overrun !== 1'b0 || rx_byte !== 8'h00) $display("FAIL mid_wr_regs got %0d/%b/%h want 0/0/00", tx_count, overrun, rx_byte); else passed++;
            end
        end
        total++; if (!seen) $display("FAIL mid_wr_timeout got no write want write"); else passed++;
        sif.tbr = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (sif.ioaddr !== 2'b11 || sif.iorw !== 1'b0 || databus !== 8'h00) $display("FAIL rehi got %b%b %h want 110 00", sif.ioaddr, sif.iorw, databus); else passed++;
        @(negedge clk);
        total++; if (sif.ioaddr !== 2'b10 || sif.iorw !== 1'b0 || databus !== 8'h50) $display("FAIL relo got %b%b %h want 100 50", sif.ioaddr, sif.iorw, databus); else passed++;
        @(negedge clk);
        total++; if (sif.iocs !== 1'b1 || sif.ioaddr !== 2'b01 || databus !== 8'hA5) $display("FAIL reidle got %b%b %h want 101 a5", sif.iocs, sif.ioaddr, databus); else passed++;
    endtask

    initial begin
        test_reset();
        test_echo();
        test_br_change();
        test_overrun();
        test_rda_hold();
        test_reset_mid_wr();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion (%0d/%0d)", passed, total);
        $fatal(1, "watchdog");
    end
endmodule
